// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read bus between the IF stage and the I-cache/memory.
// The fetch unit issues the request; the memory answers with data and busywait.
interface instruction_fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_readdata;
    logic        imem_busywait;

    modport master (
        output imem_addr,
        output imem_read,
        input  imem_readdata,
        input  imem_busywait
    );

    modport slave (
        input  imem_addr,
        input  imem_read,
        output imem_readdata,
        output imem_busywait
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, reads instruction memory over a
// read/busywait handshake and loads the IF/ID register. A one-entry hold buffer
// absorbs a word that completes while the hazard unit stalls, and a redirect
// that arrives mid-read waits for the in-flight read to drain before refetching.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    instruction_fetch_unit_if.master  bus,
    output logic [31:0]               if_id_pc,
    output logic [31:0]               if_id_inst,
    output logic                      if_id_valid,
    output logic [6:0]                opcode,
    output logic [2:0]                fun_3,
    output logic [6:0]                fun_7
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] if_id_pc_d, if_id_inst_d;
    logic        if_id_valid_d;
    logic        done;
    logic [31:0] target;

    // The memory shares RESET, so no request is presented while it is held.
    assign bus.imem_read = !RESET && (state_q != HOLD);
    assign bus.imem_addr = pc_q;
    assign done          = bus.imem_read && !bus.imem_busywait;
    // Fetch targets are word aligned; the low two bits are forced to zero.
    assign target        = redirect_pc & 32'hFFFF_FFFC;

    // Decoder-facing slices are zeroed for bubbles so the decoder sees its default case.
    assign opcode = if_id_valid ? if_id_inst[6:0]   : 7'b000_0000;
    assign fun_3  = if_id_valid ? if_id_inst[14:12] : 3'b000;
    assign fun_7  = if_id_valid ? if_id_inst[31:25] : 7'b000_0000;

    // Next-state logic: redirect beats stall in every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        hold_pc_d     = hold_pc_q;
        hold_inst_d   = hold_inst_q;
        if_id_pc_d    = if_id_pc;
        if_id_inst_d  = if_id_inst;
        if_id_valid_d = if_id_valid;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if_id_valid_d = 1'b0;
                    if (done) begin
                        pc_d = target;
                    end else begin
                        // The read in flight must finish before the new target is fetched.
                        pending_d = target;
                        state_d   = DRAIN;
                    end
                end else if (stall) begin
                    if (done) begin
                        hold_pc_d   = pc_q;
                        hold_inst_d = bus.imem_readdata;
                        state_d     = HOLD;
                    end
                end else if (done) begin
                    if_id_pc_d    = pc_q;
                    if_id_inst_d  = bus.imem_readdata;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_q + 32'd4;
                end else begin
                    if_id_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                // The newest redirect target wins, even on the completing edge.
                if (done) begin
                    pc_d    = redirect ? target : pending_q;
                    state_d = FETCH;
                end else if (redirect) begin
                    pending_d = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d          = target;
                    if_id_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (!stall) begin
                    if_id_pc_d    = hold_pc_q;
                    if_id_inst_d  = hold_inst_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = hold_pc_q + 32'd4;
                    state_d       = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State register; reset also drops any outstanding read.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            pending_q   <= 32'h0000_0000;
            hold_pc_q   <= 32'h0000_0000;
            hold_inst_q <= 32'h0000_0000;
            if_id_pc    <= 32'h0000_0000;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            if_id_pc    <= if_id_pc_d;
            if_id_inst  <= if_id_inst_d;
            if_id_valid <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by randomized
// stall/redirect/busywait/reset traffic against a behavioural fetch model.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        bw;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [6:0]  opcode;
    logic [2:0]  fun_3;
    logic [6:0]  fun_7;

    int n_checks;
    int n_fail;

    // Behavioural model: where the fetcher is, what it is doing, and what IF/ID shows.
    localparam int M_RUN = 0, M_FLUSH = 1, M_PARKED = 2;
    int          m_mode;
    logic [31:0] m_pc, m_target, m_bpc, m_binst, m_ifpc, m_ifinst;
    logic        m_ifv;

    instruction_fetch_unit_if bus ();

    // Memory image: the program words from the plan at 0..C, a hash elsewhere.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            32'hC:   return 32'h0000_006F;
            default: return (a * 32'h9E37_79B1) + 32'h0000_0013;
        endcase
    endfunction

    assign bus.imem_readdata = word_at(bus.imem_addr);
    assign bus.imem_busywait = bw;

    instruction_fetch_unit dut (
        .CLK         (CLK),
        .RESET       (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus.master),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid),
        .opcode      (opcode),
        .fun_3       (fun_3),
        .fun_7       (fun_7)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance the model by one clock using the inputs seen at that edge.
    task automatic model_step();
        logic        done;
        logic [31:0] tgt;
        tgt  = redirect_pc & 32'hFFFF_FFFC;
        done = (m_mode != M_PARKED) && !bw;
        if (rst) begin
            m_mode = M_RUN; m_pc = 32'h0; m_target = 32'h0; m_bpc = 32'h0; m_binst = 32'h0;
            m_ifpc = 32'h0; m_ifinst = 32'h0000_0013; m_ifv = 1'b0;
        end else if (m_mode == M_RUN) begin
            if (redirect) begin
                m_ifv = 1'b0;
                if (done) m_pc = tgt;
                else begin m_target = tgt; m_mode = M_FLUSH; end
            end else if (stall) begin
                if (done) begin m_bpc = m_pc; m_binst = word_at(m_pc); m_mode = M_PARKED; end
            end else if (done) begin
                m_ifpc = m_pc; m_ifinst = word_at(m_pc); m_ifv = 1'b1; m_pc = m_pc + 32'd4;
            end else begin
                m_ifv = 1'b0;
            end
        end else if (m_mode == M_FLUSH) begin
            if (redirect) m_target = tgt;
            if (done) begin m_pc = m_target; m_mode = M_RUN; end
        end else begin
            if (redirect) begin
                m_pc = tgt; m_ifv = 1'b0; m_mode = M_RUN;
            end else if (!stall) begin
                m_ifpc = m_bpc; m_ifinst = m_binst; m_ifv = 1'b1; m_pc = m_bpc + 32'd4; m_mode = M_RUN;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; bw = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.imem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", bus.imem_read); end
        n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", bus.imem_addr); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifpc: got %h want 00000000", if_id_pc); end
        n_checks++; if (if_id_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h want 00000013", if_id_inst); end
        n_checks++; if ({opcode, fun_3, fun_7} !== 17'h0) begin n_fail++; $display("FAIL reset_decode: got %h want 0", {opcode, fun_3, fun_7}); end
    endtask

    task automatic test_fetch();
        logic [31:0] words[4];
        logic [6:0]  ops[4];
        words = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};
        ops   = '{7'b0010011, 7'b0010011, 7'b0110011, 7'b1101111};
        rst = 1'b0;
        #1;
        n_checks++; if (bus.imem_read !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_first_req: got read=%b addr=%h want read=1 addr=00000000", bus.imem_read, bus.imem_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (if_id_pc !== 32'(i * 4) || if_id_inst !== words[i] || if_id_valid !== 1'b1) begin
                n_fail++; $display("FAIL fetch_ifid%0d: got pc=%h inst=%h v=%b want pc=%h inst=%h v=1", i, if_id_pc, if_id_inst, if_id_valid, 32'(i * 4), words[i]);
            end
            n_checks++; if (opcode !== ops[i]) begin n_fail++; $display("FAIL fetch_opcode%0d: got %b want %b", i, opcode, ops[i]); end
        end
        // Redirect on a completing edge goes straight to the target.
        redirect = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL fetch_redirect: got v=%b addr=%h want v=0 addr=00000004", if_id_valid, bus.imem_addr); end
    endtask

    task automatic test_busywait();
        bw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.imem_addr !== 32'h4 || bus.imem_read !== 1'b1 || if_id_valid !== 1'b0) begin
                n_fail++; $display("FAIL bw_wait%0d: got addr=%h read=%b v=%b want addr=00000004 read=1 v=0", i, bus.imem_addr, bus.imem_read, if_id_valid);
            end
        end
        bw = 1'b0;
        tick();
        n_checks++; if (if_id_pc !== 32'h4 || if_id_inst !== 32'h00A0_0113 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL bw_done: got pc=%h inst=%h v=%b want pc=00000004 inst=00a00113 v=1", if_id_pc, if_id_inst, if_id_valid);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (bus.imem_read !== 1'b0 || if_id_pc !== 32'h4 || if_id_inst !== 32'h00A0_0113) begin
                n_fail++; $display("FAIL stall_hold%0d: got read=%b pc=%h inst=%h want read=0 pc=00000004 inst=00a00113", i, bus.imem_read, if_id_pc, if_id_inst);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++; if (if_id_pc !== 32'h8 || if_id_inst !== 32'h0020_81B3 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got pc=%h inst=%h v=%b want pc=00000008 inst=002081b3 v=1", if_id_pc, if_id_inst, if_id_valid);
        end
        n_checks++; if (bus.imem_read !== 1'b1 || bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_next_req: got read=%b addr=%h want read=1 addr=0000000c", bus.imem_read, bus.imem_addr); end
    endtask

    task automatic test_drain();
        bw = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'hC || bus.imem_read !== 1'b1 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_enter: got addr=%h read=%b v=%b want addr=0000000c read=1 v=0", bus.imem_addr, bus.imem_read, if_id_valid);
        end
        tick();
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'hC || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_second: got addr=%h v=%b want addr=0000000c v=0", bus.imem_addr, if_id_valid); end
        // Stall is ignored while draining.
        bw = 1'b0; stall = 1'b1;
        tick();
        stall = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'h200 || bus.imem_read !== 1'b1 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_exit: got addr=%h read=%b v=%b want addr=00000200 read=1 v=0", bus.imem_addr, bus.imem_read, if_id_valid);
        end
        n_checks++; if (if_id_inst !== 32'h0020_81B3) begin n_fail++; $display("FAIL drain_discard: got inst=%h want 002081b3", if_id_inst); end
    endtask

    task automatic test_hold_redirect();
        stall = 1'b1;
        tick();
        n_checks++; if (bus.imem_read !== 1'b0) begin n_fail++; $display("FAIL holdr_enter: got read=%b want 0", bus.imem_read); end
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect = 1'b0; stall = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || opcode !== 7'b0 || bus.imem_addr !== 32'h300 || bus.imem_read !== 1'b1) begin
            n_fail++; $display("FAIL holdr_flush: got v=%b op=%b addr=%h read=%b want v=0 op=0 addr=00000300 read=1", if_id_valid, opcode, bus.imem_addr, bus.imem_read);
        end
        tick();
        n_checks++; if (if_id_pc !== 32'h300 || if_id_inst !== word_at(32'h300) || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL holdr_refetch: got pc=%h inst=%h v=%b want pc=00000300 inst=%h v=1", if_id_pc, if_id_inst, if_id_valid, word_at(32'h300));
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect = 1'b0; bw = 1'b1;
        tick();
        n_checks++; if (bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL rstmid_addr: got %h want 00000020", bus.imem_addr); end
        rst = 1'b1;
        tick();
        n_checks++; if (bus.imem_addr !== 32'h0 || if_id_inst !== 32'h0000_0013 || if_id_valid !== 1'b0 || bus.imem_read !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state: got addr=%h inst=%h v=%b read=%b want 00000000 00000013 0 0", bus.imem_addr, if_id_inst, if_id_valid, bus.imem_read);
        end
        rst = 1'b0; bw = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align: got %h want fffffffc", bus.imem_addr); end
        tick();
        n_checks++; if (if_id_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: got ifpc=%h addr=%h want fffffffc 00000000", if_id_pc, bus.imem_addr);
        end
    endtask

    task automatic test_random();
        logic exp_read;
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom();
            bw          = ($urandom_range(0, 2) == 0);
            tick();
            exp_read = !rst && (m_mode != M_PARKED);
            n_checks++; if (bus.imem_read !== exp_read || bus.imem_addr !== m_pc) begin
                n_fail++; $display("FAIL rand_req c=%0d: got read=%b addr=%h want read=%b addr=%h", c, bus.imem_read, bus.imem_addr, exp_read, m_pc);
            end
            n_checks++; if (if_id_valid !== m_ifv || if_id_pc !== m_ifpc || if_id_inst !== m_ifinst) begin
                n_fail++; $display("FAIL rand_ifid c=%0d: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h", c, if_id_valid, if_id_pc, if_id_inst, m_ifv, m_ifpc, m_ifinst);
            end
            n_checks++; if (opcode !== (m_ifv ? m_ifinst[6:0] : 7'h0) || fun_3 !== (m_ifv ? m_ifinst[14:12] : 3'h0) || fun_7 !== (m_ifv ? m_ifinst[31:25] : 7'h0)) begin
                n_fail++; $display("FAIL rand_decode c=%0d: got op=%b f3=%b f7=%b for inst=%h v=%b", c, opcode, fun_3, fun_7, m_ifinst, m_ifv);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; bw = 1'b0;
        m_mode = M_RUN; m_pc = 32'h0; m_target = 32'h0; m_bpc = 32'h0; m_binst = 32'h0;
        m_ifpc = 32'h0; m_ifinst = 32'h0000_0013; m_ifv = 1'b0;
        @(negedge CLK);
        test_reset();
        test_fetch();
        test_busywait();
        test_stall();
        test_drain();
        test_hold_redirect();
        test_reset_mid_and_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 32-bit RV32I pipeline: holds the PC, reads the instruction memory/I-cache over a read/busywait handshake, and loads the IF/ID register.
- Exports opcode, fun_3 and fun_7 slices of the IF/ID instruction directly to the control decoder.
- Handles hazard stalls with a one-entry hold buffer, and branch/jump redirects with a drain of any in-flight memory read.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INST, 32'h00000013, IF/ID instruction value on reset (addi x0,x0,0).

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  synchronous, active-high reset.
stall  input  1  hazard unit hold request; IF/ID must not change.
redirect  input  1  branch/jump taken; flush and refetch.
redirect_pc  input  32  redirect target, byte address, bits [1:0] ignored (treated as 0).
imem_addr  output  32  instruction memory read address (current PC).
imem_read  output  1  instruction memory read request.
imem_readdata  input  32  instruction word; valid on a completion edge.
imem_busywait  input  1  high while the memory cannot complete the read.
if_id_pc  output  32  PC of the instruction held in IF/ID.
if_id_inst  output  32  instruction held in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction.
opcode  output  7  if_id_inst[6:0] when valid, else 7'b0000000.
fun_3  output  3  if_id_inst[14:12] when valid, else 0.
fun_7  output  7  if_id_inst[31:25] when valid, else 0.

Behaviour:
- One clock, CLK; RESET is synchronous and active-high; all state updates on the rising edge.
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST.
  - Hold buffer empty; pending target=0.
  - imem_read=0 while RESET is high.
  - opcode/fun_3/fun_7 = 0, so the decoder produces the default case with all enables low.
- Completion: a rising edge where imem_read=1 and imem_busywait=0; imem_readdata is captured at that edge. imem_addr is stable for the whole request.
- States:
  - FETCH: imem_read=1, imem_addr=pc.
  - DRAIN: imem_read=1, imem_addr=pc (the stale address).
  - HOLD: imem_read=0.
- FETCH, with priority in this order:
  1. redirect=1 and completion: discard data; pc<=redirect_pc; if_id_valid<=0; stay in FETCH.
  2. redirect=1 and no completion: pending<=redirect_pc; if_id_valid<=0; go to DRAIN. The in-flight read is never abandoned.
  3. stall=1 and completion: hold buffer<={pc, data}; go to HOLD; IF/ID unchanged.
  4. stall=1 and no completion: IF/ID unchanged.
  5. stall=0 and completion: IF/ID<={pc, data, valid=1}; pc<=pc+4, wrapping mod 2^32.
  6. stall=0 and no completion: if_id_valid<=0 (bubble); if_id_pc and if_id_inst keep their old values.
- DRAIN:
  - redirect=1 overwrites pending (latest target wins).
  - On completion: discard data; pc<=pending; go to FETCH.
  - if_id_valid stays 0 throughout; stall is ignored.
- HOLD:
  - redirect=1: discard the buffer; pc<=redirect_pc; if_id_valid<=0; go to FETCH. Redirect has priority over stall.
  - stall=1: no change.
  - stall=0: IF/ID<=buffer with valid=1; pc<=buffer pc+4; go to FETCH. The next request starts the cycle after.
- Simultaneous redirect and stall: redirect wins in every state.
- RESET asserted mid-request or in any state: reset values apply at the next edge, and any outstanding read is dropped (memory is reset by the same RESET).
- Throughput: one instruction per cycle when busywait stays low and there are no stalls. Latency is request to IF/ID in 1 cycle plus the busywait cycles.

Test Plan:
- Reset, then 4 zero-wait fetches (mem[0..3]=0x00500093, 0x00A00113, 0x002081B3, 0x0000006F) -> if_id_pc 0,4,8,C on consecutive cycles; valid=1; opcode 0010011,0010011,0110011,1101111.
- busywait high 3 cycles on PC 0x4 -> imem_addr held at 0x4; if_id_valid=0 for 3 cycles; then if_id_inst=0x00A00113 and if_id_pc=0x4.
- stall=1 for 2 cycles while the read of 0x8 completes -> state HOLD, imem_read=0, IF/ID keeps 0x4; after release if_id_pc=0x8, the next request is to 0xC, and no instruction is lost or duplicated.
- redirect to 0x100 while busywait is high on 0xC -> imem_addr stays 0xC until completion; word discarded; if_id_valid=0; next request 0x100; second redirect to 0x200 during DRAIN -> fetch goes to 0x200.
- redirect=1 and stall=1 in HOLD -> buffer discarded; if_id_valid=0; opcode=0; next imem_addr=redirect_pc.
- RESET asserted mid-busywait at PC 0x20 -> next edge pc=RESET_PC, if_id_inst=0x00000013, valid=0; pc=0xFFFFFFFC fetch -> next pc=0x00000000.
